// File: rtl/dct2d_rowcol_seq.sv
// 8x8 2-D DCT sequencer: streams rows through one shared 1-D core into a transpose
// buffer, then streams the buffer columns back through the same core to the output.
module dct2d_rowcol_seq #(
    parameter int W = 32,
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0][W-1:0] in_row,
    output logic                core_in_valid,
    input  logic                core_in_ready,
    output logic [N-1:0][W-1:0] core_in,
    input  logic                core_out_valid,
    output logic                core_out_ready,
    input  logic [N-1:0][W-1:0] core_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0][W-1:0] out_col,
    output logic [2:0]          out_idx,
    output logic                out_last,
    output logic                busy
);

    generate
        if (N != 8) begin : g_n_check
            $error("dct2d_rowcol_seq: N must be 8, the core is 8-point");
        end
    endgenerate

    typedef enum logic {
        ROW = 1'b0,
        COL = 1'b1
    } state_t;

    // All control state lives in one registered struct so it can be probed as a unit.
    typedef struct packed {
        state_t     state;
        logic [3:0] feed_cnt;
        logic [3:0] recv_cnt;
        logic       busy;
    } ctrl_t;

    ctrl_t ctrl;

    logic [W-1:0]         row_buf [N][N];
    logic [N-1:0][W-1:0]  col_vec;
    logic                 feeding;
    logic                 in_hs;
    logic                 core_in_hs;
    logic                 core_out_hs;
    logic                 out_hs;

    assign feeding     = (ctrl.feed_cnt < 4'd8);
    assign in_hs       = in_valid && in_ready;
    assign core_in_hs  = core_in_valid && core_in_ready;
    assign core_out_hs = core_out_valid && core_out_ready;
    assign out_hs      = out_valid && out_ready;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            col_vec[k] = row_buf[k][ctrl.feed_cnt[2:0]];
        end
    end

    // Handshake outputs are forced low while reset is asserted, independent of the core.
    always_comb begin
        in_ready       = 1'b0;
        core_in_valid  = 1'b0;
        core_in        = in_row;
        core_out_ready = 1'b0;
        out_valid      = 1'b0;
        if (rst_n) begin
            if (ctrl.state == ROW) begin
                in_ready       = core_in_ready && feeding;
                core_in_valid  = in_valid && feeding;
                core_out_ready = 1'b1;
            end else begin
                core_in_valid  = feeding;
                core_in        = col_vec;
                core_out_ready = out_ready;
                out_valid      = core_out_valid;
            end
        end
    end

    assign out_col  = core_out;
    assign out_idx  = ctrl.recv_cnt[2:0];
    assign out_last = out_valid && (ctrl.recv_cnt == 4'd7);
    assign busy     = ctrl.busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl <= '{state: ROW, feed_cnt: 4'd0, recv_cnt: 4'd0, busy: 1'b0};
        end else begin
            if (core_in_hs) ctrl.feed_cnt <= ctrl.feed_cnt + 4'd1;
            if (in_hs)      ctrl.busy     <= 1'b1;
            unique case (ctrl.state)
                ROW: begin
                    if (core_out_hs) begin
                        if (ctrl.recv_cnt == 4'd7) begin
                            ctrl.state    <= COL;
                            ctrl.feed_cnt <= 4'd0;
                            ctrl.recv_cnt <= 4'd0;
                        end else begin
                            ctrl.recv_cnt <= ctrl.recv_cnt + 4'd1;
                        end
                    end
                end
                COL: begin
                    if (out_hs) begin
                        if (ctrl.recv_cnt == 4'd7) begin
                            ctrl.state    <= ROW;
                            ctrl.feed_cnt <= 4'd0;
                            ctrl.recv_cnt <= 4'd0;
                            ctrl.busy     <= 1'b0;
                        end else begin
                            ctrl.recv_cnt <= ctrl.recv_cnt + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Row results land in buffer row recv_cnt; contents need no reset.
    always_ff @(posedge clk) begin
        if (ctrl.state == ROW && core_out_hs) begin
            for (int k = 0; k < N; k++) begin
                row_buf[ctrl.recv_cnt[2:0]][k] <= core_out[k];
            end
        end
    end

endmodule

// File: tb/tb_dct2d_rowcol_seq.sv
// Bench for dct2d_rowcol_seq: a lane-permuting stub core with latency 3 and a
// matrix-level reference model of the row-column decomposition.
module tb_dct2d_rowcol_seq;

    localparam int W  = 32;
    localparam int N  = 8;
    localparam int BW = N * W;

    typedef logic [N-1:0][W-1:0] row_t;
    typedef struct {
        row_t d;
        int   rdy;
    } item_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    row_t       in_row;
    logic       core_in_valid;
    logic       core_in_ready;
    row_t       core_in;
    logic       core_out_valid;
    logic       core_out_ready;
    row_t       core_out;
    logic       out_valid;
    logic       out_ready;
    row_t       out_col;
    logic [2:0] out_idx;
    logic       out_last;
    logic       busy;
    logic       stub_ov;

    dct2d_rowcol_seq #(.W(W), .N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .core_in_valid(core_in_valid), .core_in_ready(core_in_ready), .core_in(core_in),
        .core_out_valid(core_out_valid), .core_out_ready(core_out_ready), .core_out(core_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col),
        .out_idx(out_idx), .out_last(out_last), .busy(busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign core_out_valid = rst_n && stub_ov;

    // ---------------- environment state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          rot = 0;
    bit          in_stall = 0;
    int          out_mode = 0;
    item_t       core_q[$];
    logic [BW-1:0] exp_q[$];
    logic [2:0]  idx_q[$];
    logic [W-1:0] blk [N][N];
    int          core_hs_cnt = 0;
    int          in_hs_cnt = 0;
    int          out_hs_cnt = 0;
    int          last_out_cyc = -1;
    bit          prev_stall = 0;
    row_t        prev_col;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic row_t core_f(input row_t v, input int r);
        row_t o;
        for (int k = 0; k < N; k++) o[k] = v[(k + r) % N];
        return o;
    endfunction

    // Reference: 1-D transform on every row, then on every column of the result.
    task automatic push_expected();
        row_t rr [N];
        row_t v;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) v[c] = blk[r][c];
            rr[r] = core_f(v, rot);
        end
        for (int c = 0; c < N; c++) begin
            for (int j = 0; j < N; j++) v[j] = rr[j][c];
            exp_q.push_back(core_f(v, rot));
            idx_q.push_back(3'(c));
        end
    endtask

    // ---------------- stub core + monitor ----------------
    task automatic stub_drive();
        core_in_ready = (core_q.size() < 4) && (!in_stall || (cyc % 2 == 0));
        stub_ov       = (core_q.size() > 0) && (core_q[0].rdy <= cyc);
        core_out      = stub_ov ? core_q[0].d : '0;
        case (out_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic monitor();
        item_t it;
        if (!rst_n) begin
            core_q.delete();
            prev_stall = 0;
        end else begin
            if (core_in_valid && core_in_ready) begin
                it.d   = core_f(core_in, rot);
                it.rdy = cyc + 3;
                core_q.push_back(it);
                core_hs_cnt++;
            end
            if (in_valid && in_ready) in_hs_cnt++;
            if (out_valid) check("out_last_flag", out_last, (out_idx == 3'd7));
            if (prev_stall) begin
                check("stall_valid_held", out_valid, 1'b1);
                check("stall_data_held", out_col, prev_col);
            end
            if (core_out_valid && core_out_ready) void'(core_q.pop_front());
            if (out_valid && out_ready) begin
                out_hs_cnt++;
                check("busy_on_beat", busy, 1'b1);
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    check("out_col", out_col, exp_q.pop_front());
                    check("out_idx", out_idx, idx_q.pop_front());
                end
                if (out_last) last_out_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_col   = out_col;
        end
        cyc++;
    endtask

    always begin
        @(negedge clk);
        stub_drive();
        #2;
        monitor();
    end

    // ---------------- driver tasks ----------------
    task automatic send_rows(input int nrows, input bit chk_mirror, output int first_cyc);
        int t;
        first_cyc = -1;
        for (int r = 0; r < nrows; r++) begin
            @(negedge clk);
            in_valid = 1'b1;
            for (int k = 0; k < N; k++) in_row[k] = blk[r][k];
            for (t = 0; t < 200; t++) begin
                #1;
                if (chk_mirror) check("in_ready_mirror", in_ready, core_in_ready);
                if (in_ready) break;
                @(negedge clk);
            end
            if (t == 200) check("row_accept_timeout", 1'b1, 1'b0);
            if (r == 0) first_cyc = cyc;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        for (t = 0; t < 600; t++) begin
            @(negedge clk);
            #3;
            if (exp_q.size() == 0 && busy === 1'b0) break;
        end
        if (t == 600) check("block_done_timeout", 1'b1, 1'b0);
    endtask

    task automatic fill_random(input logic [W-1:0] add);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) blk[r][c] = $urandom() + add;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int fc, fc2, c0, i0, o0;
        logic [W-1:0] saved [N][N];
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_row   = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_core_in_valid", core_in_valid, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_core_out_ready", core_out_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_busy", busy, 1'b0);
        check("idle_in_ready", in_ready, 1'b1);
        check("idle_out_valid", out_valid, 1'b0);

        // identity core, ramp block, no backpressure
        rot = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) blk[r][c] = 32'(16 * r + c);
        push_expected();
        o0 = out_hs_cnt;
        send_rows(N, 1'b1, fc);
        check("busy_after_rows", busy, 1'b1);
        wait_done();
        check("beats_block1", 32'(out_hs_cnt - o0), 32'd8);

        // same block with output stalls 1,0,0,1
        out_mode = 1;
        push_expected();
        send_rows(N, 1'b0, fc);
        wait_done();

        // core input ready every other cycle; count core transactions
        out_mode = 0;
        in_stall = 1;
        fill_random('0);
        push_expected();
        c0 = core_hs_cnt; i0 = in_hs_cnt; o0 = out_hs_cnt;
        send_rows(N, 1'b1, fc);
        wait_done();
        check("core_tx_count", 32'(core_hs_cnt - c0), 32'd16);
        check("row_tx_count", 32'(in_hs_cnt - i0), 32'd8);
        check("col_beats", 32'(out_hs_cnt - o0), 32'd8);
        in_stall = 0;

        // back-to-back blocks, permuting core, second block +1000
        rot = 3;
        out_mode = 2;
        fill_random('0);
        saved = blk;
        push_expected();
        send_rows(N, 1'b0, fc);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) blk[r][c] = saved[r][c] + 32'd1000;
        push_expected();
        send_rows(N, 1'b0, fc2);
        check("b2b_order", (fc2 > last_out_cyc), 1'b1);
        wait_done();

        // reset after 5 rows: partial block discarded
        out_mode = 0;
        fill_random('0);
        send_rows(5, 1'b0, fc);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        repeat (2) begin
            #1;
            check("midrst_in_ready", in_ready, 1'b0);
            check("midrst_out_valid", out_valid, 1'b0);
            check("midrst_busy", busy, 1'b0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        rot = 5;
        out_mode = 2;
        fill_random('0);
        push_expected();
        send_rows(N, 1'b0, fc);
        wait_done();

        // random blocks under random stalls
        for (int b = 0; b < 3; b++) begin
            rot = int'($urandom_range(0, 7));
            in_stall = 1'($urandom_range(0, 1));
            fill_random('0);
            push_expected();
            send_rows(N, 1'b0, fc);
            wait_done();
        end

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dct2d_rowcol_seq.md
Name: dct2d_rowcol_seq

Overview:
- Sequences one shared 8-point 1-D DCT core (dct8_chen_ts valid/ready interface, 8 lanes of W bits) to compute an 8x8 2-D DCT by row-column decomposition.
- Row pass: accepts 8 input rows and streams them through the core. Results are stored in an internal 8x8 transpose buffer.
- Column pass: feeds the 8 buffer columns back through the core and forwards the core results to the output stream as 8 column beats.
- Sits between the block-fetch stage and the quantizer.

Parameters:
- W, 32, lane width of input, core ports, buffer and output (no width growth inside this block).
- N, 8, block dimension; fixed at 8 (core is 8-point). Any other value is a synthesis error.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input row valid
- in_ready  out  1  input row accepted when in_valid && in_ready
- in_row  in  8xW  input row, lane k = column k
- core_in_valid  out  1  to core in_valid
- core_in_ready  in  1  from core in_ready
- core_in  out  8xW  to core in0..in7
- core_out_valid  in  1  from core out_valid
- core_out_ready  out  1  to core out_ready
- core_out  in  8xW  from core out0..out7
- out_valid  out  1  output column valid
- out_ready  in  1  downstream ready
- out_col  out  8xW  output column, lane k = 2-D coefficient row k
- out_idx  out  3  column index of current output beat
- out_last  out  1  high on beat with out_idx==7
- busy  out  1  high when any row has been accepted and the block is not finished

Behaviour:
- Clock and reset: one clock clk. Reset rst_n is asynchronous, active-low.
- Reset state: state=ROW, feed_cnt=0, recv_cnt=0, busy=0.
- Outputs are combinational from the registered state. While rst_n=0: in_ready=0, core_in_valid=0, out_valid=0, core_out_ready=0.
- Buffer contents are not reset.

- State ROW:
  - in_ready = core_in_ready && feed_cnt<8.
  - core_in_valid = in_valid && feed_cnt<8; core_in = in_row (direct pass-through, no register).
  - feed_cnt increments on the core input handshake.
  - core_out_ready=1. On core_out_valid, buffer row recv_cnt <= core_out; recv_cnt increments.
  - Feeding and draining overlap freely.
  - out_valid=0.
  - When the 8th result is captured: go to COL next cycle; feed_cnt, recv_cnt <= 0.

- State COL:
  - in_ready=0.
  - core_in_valid = feed_cnt<8; core_in lane k = buf[k][feed_cnt]. feed_cnt increments on handshake.
  - out_valid = core_out_valid; out_col = core_out; core_out_ready = out_ready.
  - out_idx = recv_cnt; recv_cnt increments on the output handshake.
  - On the handshake with recv_cnt==7: go to ROW next cycle, counters cleared.
  - A new block may enter the very next cycle (one bubble cycle between blocks).

- Buffer hazards: buffer writes occur only in ROW and reads only in COL, so there is no read/write hazard.
- Core behaviour: core latency and backpressure are opaque to this block. Correctness relies only on in-order core outputs.
- Core output in COL state: the core asserting core_out_valid while feed_cnt==0 in COL is legal and is passed through unchanged.
- Backpressure: out_ready=0 stalls the core output, never drops data. The core's own ready then throttles column feeding.
- busy: 1 from the first accepted row until the last output handshake. It falls in the cycle after out_last is handshaken.
- Counters: all counters are 4 bits. No counter ever exceeds 8; reaching 8 is the terminal value.
- Reset mid-block: the partial block is discarded. The core must be reset by the same rst_n, so no stale core results arrive after reset.
- Arithmetic: no arithmetic on data. Scaling/FRAC handling belongs to the core; all values pass bit-exact.

Test Plan:
- Identity stub core (latency 3, always ready); in row r lane c = 16r+c; out_ready=1 -> 8 beats, beat c lane k = 16k+c, out_idx 0..7, out_last only on beat 7.
- Same stimulus with out_ready toggling 1,0,0,1 -> identical data sequence, no beat lost or duplicated, out_valid stays high while stalled.
- Stub core with core_in_ready low every other cycle -> in_ready mirrors it during ROW; exactly 8 row and 8 column core transactions.
- Two back-to-back blocks (second block values +1000) -> second block's rows accepted only after first block's out_last; outputs are correct per block.
- rst_n pulsed low after 5 rows accepted -> in_ready=0 and out_valid=0 during reset. A fresh full block afterwards yields the correct 8 beats.
- Real dct8_chen_ts core (FRAC=8), all inputs 256 -> only beat 0 lane 0 is nonzero; matches golden 2-D model within 1 LSB.
